// File: rtl/vortex_mem_beat_serializer_if.sv
// Bundle of the Vortex line-request/response channel and the word-wide bus channel.
// The serializer connects through the master modport; the environment uses the slave modport.
interface vortex_mem_beat_serializer_if #(
  parameter int LINE_WIDTH     = 512,
  parameter int WORD_WIDTH     = 32,
  parameter int MEM_ADDR_WIDTH = 26,
  parameter int MEM_TAG_WIDTH  = 56
) ();

  // Vortex line request
  logic                      mem_req_valid;
  logic                      mem_req_rw;
  logic [LINE_WIDTH/8-1:0]   mem_req_byteen;
  logic [MEM_ADDR_WIDTH-1:0] mem_req_addr;
  logic [LINE_WIDTH-1:0]     mem_req_data;
  logic [MEM_TAG_WIDTH-1:0]  mem_req_tag;
  logic                      mem_req_ready;

  // Vortex line response (reads only)
  logic                      mem_rsp_valid;
  logic [LINE_WIDTH-1:0]     mem_rsp_data;
  logic [MEM_TAG_WIDTH-1:0]  mem_rsp_tag;
  logic                      mem_rsp_ready;

  // Word-wide bus request
  logic                      bus_req_valid;
  logic                      bus_req_wen;
  logic [31:0]               bus_req_addr;
  logic [WORD_WIDTH-1:0]     bus_req_wdata;
  logic [WORD_WIDTH/8-1:0]   bus_req_strobe;
  logic                      bus_req_ready;

  // Word-wide bus response
  logic                      bus_rsp_valid;
  logic [WORD_WIDTH-1:0]     bus_rsp_rdata;
  logic                      bus_rsp_error;

  modport master (
    input  mem_req_valid, mem_req_rw, mem_req_byteen, mem_req_addr, mem_req_data, mem_req_tag,
    output mem_req_ready,
    output mem_rsp_valid, mem_rsp_data, mem_rsp_tag,
    input  mem_rsp_ready,
    output bus_req_valid, bus_req_wen, bus_req_addr, bus_req_wdata, bus_req_strobe,
    input  bus_req_ready,
    input  bus_rsp_valid, bus_rsp_rdata, bus_rsp_error
  );

  modport slave (
    output mem_req_valid, mem_req_rw, mem_req_byteen, mem_req_addr, mem_req_data, mem_req_tag,
    input  mem_req_ready,
    input  mem_rsp_valid, mem_rsp_data, mem_rsp_tag,
    output mem_rsp_ready,
    input  bus_req_valid, bus_req_wen, bus_req_addr, bus_req_wdata, bus_req_strobe,
    output bus_req_ready,
    output bus_rsp_valid, bus_rsp_rdata, bus_rsp_error
  );

endinterface

// File: rtl/vortex_mem_beat_serializer.sv
// Splits one Vortex line request into word-wide bus beats, one beat outstanding at a time,
// and reassembles read words into a single line response.
module vortex_mem_beat_serializer #(
  parameter int LINE_WIDTH     = 512,
  parameter int WORD_WIDTH     = 32,
  parameter int MEM_ADDR_WIDTH = 26,
  parameter int MEM_TAG_WIDTH  = 56
) (
  input  logic                         clk,
  input  logic                         reset,
  vortex_mem_beat_serializer_if.master sif,
  output logic                         err_sticky
);

  localparam int BEATS        = LINE_WIDTH / WORD_WIDTH;
  localparam int BEAT_W       = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int STRB_W       = WORD_WIDTH / 8;
  localparam int STRB_SHIFT   = $clog2(STRB_W);
  localparam int LINE_BYTES_W = $clog2(LINE_WIDTH / 8);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_e;

  state_e                    state_q, state_d;
  logic [BEAT_W-1:0]         beat_q, beat_d;
  logic                      rw_q;
  logic [LINE_WIDTH/8-1:0]   byteen_q;
  logic [MEM_ADDR_WIDTH-1:0] addr_q;
  logic [LINE_WIDTH-1:0]     line_q;
  logic [MEM_TAG_WIDTH-1:0]  tag_q;
  logic                      err_q;

  logic accept;
  logic rsp_take;

  assign accept   = sif.mem_req_valid && (state_q == S_IDLE);
  assign rsp_take = sif.bus_rsp_valid && (state_q == S_WAIT);

  // Priority search for the lowest beat at or above search_start with a nonzero byte-enable
  // slice. In IDLE it looks at the incoming request, elsewhere at the captured enables.
  logic [LINE_WIDTH/8-1:0] search_vec;
  int                      search_start;
  logic                    search_found;
  logic [BEAT_W-1:0]       search_idx;

  // NOTE: every signal written in always_comb gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    search_vec   = byteen_q;
    search_start = int'(beat_q) + 1;
    if (state_q == S_IDLE) begin
      search_vec   = sif.mem_req_byteen;
      search_start = 0;
    end
    search_found = 1'b0;
    search_idx   = '0;
    for (int i = BEATS - 1; i >= 0; i--) begin
      if (i >= search_start && |search_vec[i*STRB_W +: STRB_W]) begin
        search_found = 1'b1;
        search_idx   = BEAT_W'(i);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (!sif.mem_req_rw) begin
            state_d = S_ISSUE;
            beat_d  = '0;
          end else if (search_found) begin
            state_d = S_ISSUE;
            beat_d  = search_idx;
          end
          // A write with no enabled bytes has nothing to send and stays in IDLE.
        end
      end
      S_ISSUE: begin
        if (sif.bus_req_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (sif.bus_rsp_valid) begin
          if (!rw_q) begin
            if (beat_q == LAST_BEAT) begin
              state_d = S_RESP;
            end else begin
              state_d = S_ISSUE;
              beat_d  = beat_q + 1'b1;
            end
          end else if (search_found) begin
            state_d = S_ISSUE;
            beat_d  = search_idx;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_RESP: begin
        if (sif.mem_rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples
  // the pre-edge values of the others regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      beat_q   <= '0;
      rw_q     <= 1'b0;
      byteen_q <= '0;
      addr_q   <= '0;
      // NOTE: the wide line register is reset too: after reset the response data and tag
      // must read zero, not whatever a previous transaction left behind.
      line_q   <= '0;
      tag_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      if (accept) begin
        rw_q     <= sif.mem_req_rw;
        byteen_q <= sif.mem_req_byteen;
        addr_q   <= sif.mem_req_addr;
        line_q   <= sif.mem_req_data;
        tag_q    <= sif.mem_req_tag;
      end
      if (rsp_take) begin
        if (!rw_q) line_q[int'(beat_q)*WORD_WIDTH +: WORD_WIDTH] <= sif.bus_rsp_rdata;
        if (sif.bus_rsp_error) err_q <= 1'b1;
      end
    end
  end

  // Byte address of the current beat: line base plus the word offset, modulo 2^32.
  logic [31:0] line_base;
  assign line_base = 32'({addr_q, {LINE_BYTES_W{1'b0}}});

  assign sif.mem_req_ready  = (state_q == S_IDLE);

  assign sif.bus_req_valid  = (state_q == S_ISSUE);
  assign sif.bus_req_wen    = rw_q;
  assign sif.bus_req_addr   = line_base + (32'(beat_q) << STRB_SHIFT);
  assign sif.bus_req_wdata  = line_q[int'(beat_q)*WORD_WIDTH +: WORD_WIDTH];
  assign sif.bus_req_strobe = rw_q ? byteen_q[int'(beat_q)*STRB_W +: STRB_W] : '1;

  assign sif.mem_rsp_valid  = (state_q == S_RESP);
  assign sif.mem_rsp_data   = line_q;
  assign sif.mem_rsp_tag    = tag_q;

  assign err_sticky         = err_q;

endmodule

// File: tb/tb_vortex_mem_beat_serializer.sv
// Directed bench for the beat serializer: reads, sparse and empty writes, bus stalls,
// bus errors and reset in the middle of a transaction.
module tb_vortex_mem_beat_serializer;

  localparam int LW = 512;
  localparam int WW = 32;
  localparam int AW = 26;
  localparam int TW = 56;

  logic clk = 1'b0;
  logic reset;
  logic err_sticky;

  vortex_mem_beat_serializer_if #(
    .LINE_WIDTH(LW), .WORD_WIDTH(WW), .MEM_ADDR_WIDTH(AW), .MEM_TAG_WIDTH(TW)
  ) sif ();

  vortex_mem_beat_serializer #(
    .LINE_WIDTH(LW), .WORD_WIDTH(WW), .MEM_ADDR_WIDTH(AW), .MEM_TAG_WIDTH(TW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .sif       (sif),
    .err_sticky(err_sticky)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_req(input logic rw, input logic [LW/8-1:0] byteen, input logic [AW-1:0] addr,
                           input logic [LW-1:0] data, input logic [TW-1:0] tag);
    check("req_ready_before_accept", sif.mem_req_ready, 1'b1);
    sif.mem_req_valid  = 1'b1;
    sif.mem_req_rw     = rw;
    sif.mem_req_byteen = byteen;
    sif.mem_req_addr   = addr;
    sif.mem_req_data   = data;
    sif.mem_req_tag    = tag;
    tick();
    sif.mem_req_valid  = 1'b0;
    sif.mem_req_data   = '0;
    sif.mem_req_byteen = '0;
  endtask

  // Serves one beat: checks the request, optionally stalls it, then answers one cycle later.
  task automatic serve_beat(input string tag, input logic [31:0] exp_addr, input logic [3:0] exp_strb,
                            input logic exp_wen, input logic chk_wdata, input logic [31:0] exp_wdata,
                            input int stall, input logic [31:0] rdata, input logic err);
    check({tag, "_valid"}, sif.bus_req_valid, 1'b1);
    check({tag, "_addr"}, sif.bus_req_addr, exp_addr);
    check({tag, "_strobe"}, sif.bus_req_strobe, exp_strb);
    check({tag, "_wen"}, sif.bus_req_wen, exp_wen);
    if (chk_wdata) check({tag, "_wdata"}, sif.bus_req_wdata, exp_wdata);
    sif.bus_req_ready = 1'b0;
    for (int s = 0; s < stall; s++) begin
      tick();
      check({tag, "_stall_valid"}, sif.bus_req_valid, 1'b1);
      check({tag, "_stall_addr"}, sif.bus_req_addr, exp_addr);
      check({tag, "_stall_strobe"}, sif.bus_req_strobe, exp_strb);
      check({tag, "_stall_wdata"}, sif.bus_req_wdata, exp_wdata);
    end
    sif.bus_req_ready = 1'b1;
    tick();
    sif.bus_req_ready = 1'b0;
    check({tag, "_wait_no_valid"}, sif.bus_req_valid, 1'b0);
    check({tag, "_wait_no_rsp"}, sif.mem_rsp_valid, 1'b0);
    sif.bus_rsp_valid = 1'b1;
    sif.bus_rsp_rdata = rdata;
    sif.bus_rsp_error = err;
    tick();
    sif.bus_rsp_valid = 1'b0;
    sif.bus_rsp_error = 1'b0;
    sif.bus_rsp_rdata = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [LW-1:0]   exp_line;
    logic [LW-1:0]   wr_line;
    logic [LW/8-1:0] be;

    reset              = 1'b1;
    sif.mem_req_valid  = 1'b0;
    sif.mem_req_rw     = 1'b0;
    sif.mem_req_byteen = '0;
    sif.mem_req_addr   = '0;
    sif.mem_req_data   = '0;
    sif.mem_req_tag    = '0;
    sif.mem_rsp_ready  = 1'b0;
    sif.bus_req_ready  = 1'b0;
    sif.bus_rsp_valid  = 1'b0;
    sif.bus_rsp_rdata  = '0;
    sif.bus_rsp_error  = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    check("rst_req_ready", sif.mem_req_ready, 1'b1);
    check("rst_rsp_valid", sif.mem_rsp_valid, 1'b0);
    check("rst_bus_valid", sif.bus_req_valid, 1'b0);
    check("rst_err", err_sticky, 1'b0);
    check("rst_rsp_data", sif.mem_rsp_data, '0);
    check("rst_rsp_tag", sif.mem_rsp_tag, '0);

    // Zero-wait read of line 0x10: beats at 0x400..0x43C, response at cycle 33
    for (int i = 0; i < 16; i++) exp_line[i*32 +: 32] = 32'hA000_0000 + 32'(i);
    issue_req(1'b0, '1, 26'h0000010, '1, 56'h00_DEAD_BEEF_CAFE);
    for (int b = 0; b < 16; b++)
      serve_beat("rd", 32'h0000_0400 + 32'(4*b), 4'hF, 1'b0, 1'b0, 32'h0, 0,
                 32'hA000_0000 + 32'(b), 1'b0);
    check("rd_rsp_valid", sif.mem_rsp_valid, 1'b1);
    check("rd_rsp_data", sif.mem_rsp_data, exp_line);
    check("rd_rsp_tag", sif.mem_rsp_tag, 56'h00_DEAD_BEEF_CAFE);
    check("rd_req_ready_busy", sif.mem_req_ready, 1'b0);
    tick();
    check("rd_rsp_hold_valid", sif.mem_rsp_valid, 1'b1);
    check("rd_rsp_hold_data", sif.mem_rsp_data, exp_line);
    sif.mem_rsp_ready = 1'b1;
    tick();
    sif.mem_rsp_ready = 1'b0;
    check("rd_rsp_done", sif.mem_rsp_valid, 1'b0);
    check("rd_idle_ready", sif.mem_req_ready, 1'b1);

    // Sparse write: only beats 1 and 15 enabled
    for (int i = 0; i < 16; i++) wr_line[i*32 +: 32] = 32'hD000_0000 + 32'(i);
    be = '0;
    be[7:4]   = 4'hF;
    be[63:60] = 4'hF;
    issue_req(1'b1, be, 26'h2ABCDE, wr_line, 56'h11);
    serve_beat("wr2_b1", 32'h0AAF_3784, 4'hF, 1'b1, 1'b1, 32'hD000_0001, 0, 32'h0, 1'b0);
    serve_beat("wr2_b15", 32'h0AAF_37BC, 4'hF, 1'b1, 1'b1, 32'hD000_000F, 0, 32'h0, 1'b0);
    check("wr2_idle_ready", sif.mem_req_ready, 1'b1);
    check("wr2_no_bus", sif.bus_req_valid, 1'b0);
    check("wr2_no_rsp", sif.mem_rsp_valid, 1'b0);
    tick();
    check("wr2_no_rsp_later", sif.mem_rsp_valid, 1'b0);

    // Partial strobes: beat 2 = 4'h6, beat 9 = 4'h1
    be = '0;
    be[11:8]  = 4'h6;
    be[39:36] = 4'h1;
    issue_req(1'b1, be, 26'h0000002, wr_line, 56'h22);
    serve_beat("wrp_b2", 32'h0000_0088, 4'h6, 1'b1, 1'b1, 32'hD000_0002, 0, 32'h0, 1'b0);
    serve_beat("wrp_b9", 32'h0000_00A4, 4'h1, 1'b1, 1'b1, 32'hD000_0009, 0, 32'h0, 1'b0);
    check("wrp_idle_ready", sif.mem_req_ready, 1'b1);
    check("wrp_no_rsp", sif.mem_rsp_valid, 1'b0);

    // Write with no enabled bytes: no bus activity, ready again next cycle
    issue_req(1'b1, '0, 26'h0000003, wr_line, 56'h33);
    check("wr0_no_bus", sif.bus_req_valid, 1'b0);
    check("wr0_ready_next", sif.mem_req_ready, 1'b1);
    tick();
    check("wr0_no_bus_later", sif.bus_req_valid, 1'b0);
    check("wr0_no_rsp", sif.mem_rsp_valid, 1'b0);

    // Full write with beat 3 stalled for 5 cycles
    issue_req(1'b1, '1, 26'h0000000, wr_line, 56'h44);
    for (int b = 0; b < 16; b++)
      serve_beat("wrs", 32'(4*b), 4'hF, 1'b1, 1'b1, 32'hD000_0000 + 32'(b),
                 (b == 3) ? 5 : 0, 32'h0, 1'b0);
    check("wrs_idle_ready", sif.mem_req_ready, 1'b1);
    check("wrs_no_rsp", sif.mem_rsp_valid, 1'b0);
    check("wrs_no_err", err_sticky, 1'b0);

    // Read of line 0x1 with a bus error on beat 7
    for (int i = 0; i < 16; i++) exp_line[i*32 +: 32] = 32'hB000_0000 + 32'(i);
    issue_req(1'b0, '0, 26'h0000001, '0, 56'hAB_CDEF_0123_4567);
    for (int b = 0; b < 16; b++) begin
      serve_beat("rde", 32'h0000_0040 + 32'(4*b), 4'hF, 1'b0, 1'b0, 32'h0, 0,
                 32'hB000_0000 + 32'(b), b == 7);
      check("rde_err_sticky", err_sticky, b >= 7);
    end
    check("rde_rsp_valid", sif.mem_rsp_valid, 1'b1);
    check("rde_rsp_data", sif.mem_rsp_data, exp_line);
    check("rde_rsp_tag", sif.mem_rsp_tag, 56'hAB_CDEF_0123_4567);
    sif.mem_rsp_ready = 1'b1;
    tick();
    sif.mem_rsp_ready = 1'b0;
    check("rde_rsp_done", sif.mem_rsp_valid, 1'b0);
    check("rde_err_kept", err_sticky, 1'b1);

    // Reset while waiting on beat 4, then a spurious bus response
    issue_req(1'b0, '0, 26'h0000005, '0, 56'h55);
    for (int b = 0; b < 4; b++)
      serve_beat("rdr", 32'h0000_0140 + 32'(4*b), 4'hF, 1'b0, 1'b0, 32'h0, 0,
                 32'hC000_0000 + 32'(b), 1'b0);
    check("rdr_b4_valid", sif.bus_req_valid, 1'b1);
    check("rdr_b4_addr", sif.bus_req_addr, 32'h0000_0150);
    sif.bus_req_ready = 1'b1;
    tick();
    sif.bus_req_ready = 1'b0;
    check("rdr_in_wait", sif.bus_req_valid, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    sif.bus_rsp_valid = 1'b1;
    sif.bus_rsp_rdata = 32'hFFFF_FFFF;
    sif.bus_rsp_error = 1'b1;
    tick();
    sif.bus_rsp_valid = 1'b0;
    sif.bus_rsp_error = 1'b0;
    check("rdr_idle_ready", sif.mem_req_ready, 1'b1);
    check("rdr_no_bus", sif.bus_req_valid, 1'b0);
    check("rdr_no_rsp", sif.mem_rsp_valid, 1'b0);
    check("rdr_err_cleared", err_sticky, 1'b0);
    check("rdr_data_cleared", sif.mem_rsp_data, '0);
    check("rdr_tag_cleared", sif.mem_rsp_tag, '0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("rdr_quiet_rsp", sif.mem_rsp_valid, 1'b0);
      check("rdr_quiet_bus", sif.bus_req_valid, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
